// File: rtl/e_run_scan.sv
// Run-length scanner: splits each accepted occupancy vector into maximal runs of 1s
// and hands them out MSB-first, one descriptor per output handshake.

module e_cell #(
    parameter int W = 4
) (
    input  logic [W-1:0] sel_i,
    input  logic [W-1:0] x_i,
    output logic         vld_o,
    output logic [W-1:0] y_o
);
    // above[gi]: the selected bit lies strictly above position gi
    logic [W-1:0] above;
    logic [W-1:0] cand;
    logic [W-1:0] hi_cand;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == W - 1) begin : g_top
                assign above[gi]   = 1'b0;
                assign hi_cand[gi] = 1'b0;
            end else begin : g_rest
                assign above[gi]   = above[gi+1] | sel_i[gi+1];
                assign hi_cand[gi] = hi_cand[gi+1] | cand[gi+1];
            end
            // first 0 below the selected bit terminates the run
            assign cand[gi] = ~x_i[gi] & above[gi];
            assign y_o[gi]  = cand[gi] & ~hi_cand[gi];
        end
    endgenerate

    assign vld_o = (|cand) & (|sel_i);
endmodule

module e_run_scan #(
    parameter  int W  = 4,
    localparam int IW = $clog2(W),
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          in_vld_i,
    input  logic [W-1:0]  in_x_i,
    output logic          in_rdy_o,
    input  logic          flush_i,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic [IW-1:0] out_start_o,
    output logic [LW-1:0] out_len_o,
    output logic          out_last_o,
    output logic [IW-1:0] out_ord_o
);
    generate
        if (W < 2 || W > 8) begin : g_w_check
            $error("e_run_scan: W must be in 2..8");
        end
    endgenerate

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state_reg;
    logic [W-1:0]  rem_reg;
    logic [IW-1:0] ord_reg;

    logic [IW-1:0] start_idx;
    logic [W-1:0]  start_sel;
    logic          cell_vld;
    logic [W-1:0]  cell_y;
    logic [IW-1:0] end_idx;
    logic [LW-1:0] run_len;
    logic [W-1:0]  run_mask;
    logic          run_last;
    logic          rem_zero;

    assign rem_zero = (rem_reg == '0);

    always_comb begin
        start_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (rem_reg[i]) start_idx = IW'(i);
        end
        start_sel = '0;
        if (!rem_zero) start_sel[start_idx] = 1'b1;
    end

    e_cell #(.W(W)) u_cell (
        .sel_i (start_sel),
        .x_i   (rem_reg),
        .vld_o (cell_vld),
        .y_o   (cell_y)
    );

    always_comb begin
        end_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (cell_y[i]) end_idx = IW'(i);
        end
        if (rem_zero)
            run_len = '0;
        else if (cell_vld)
            run_len = LW'(start_idx) - LW'(end_idx);
        else
            run_len = LW'(start_idx) + LW'(1);
        // bits from the run start down to (but excluding) the terminating 0
        run_mask = '0;
        for (int i = 0; i < W; i++) begin
            run_mask[i] = !rem_zero && (i <= int'(start_idx)) &&
                          (!cell_vld || i > int'(end_idx));
        end
        run_last = ((rem_reg & ~run_mask) == '0);
    end

    assign in_rdy_o    = (state_reg == IDLE) && !flush_i;
    assign out_vld_o   = (state_reg == EMIT);
    assign out_start_o = start_idx;
    assign out_len_o   = run_len;
    assign out_last_o  = run_last;
    assign out_ord_o   = ord_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            ord_reg   <= '0;
        end else if (flush_i) begin
            // a beat handshaking alongside the flush still counts as delivered
            state_reg <= IDLE;
            rem_reg   <= '0;
            if (out_vld_o && out_rdy_i) ord_reg <= ord_reg + IW'(1);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_vld_i) begin
                        rem_reg   <= in_x_i;
                        ord_reg   <= '0;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_rdy_i) begin
                        rem_reg <= rem_reg & ~run_mask;
                        ord_reg <= ord_reg + IW'(1);
                        if (run_last) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_e_run_scan.sv
// Bench for e_run_scan at W=8: table vectors, hand-built flush/reset sequences,
// and random vectors checked against a run-list model.

module tb_e_run_scan;
    logic       clk = 1'b0;
    logic       arst_n;
    logic       in_vld_i;
    logic [7:0] in_x_i;
    logic       in_rdy_o;
    logic       flush_i;
    logic       out_vld_o;
    logic       out_rdy_i;
    logic [2:0] out_start_o;
    logic [3:0] out_len_o;
    logic       out_last_o;
    logic [2:0] out_ord_o;

    int n_pass = 0;
    int n_total = 0;

    e_run_scan #(.W(8)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_vld_i    (in_vld_i),
        .in_x_i      (in_x_i),
        .in_rdy_o    (in_rdy_o),
        .flush_i     (flush_i),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i),
        .out_start_o (out_start_o),
        .out_len_o   (out_len_o),
        .out_last_o  (out_last_o),
        .out_ord_o   (out_ord_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       x;
        logic [2:0]       n;
        logic [3:0][2:0]  st;
        logic [3:0][3:0]  ln;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_beat(input string tag, input int b, input int n, input int s, input int l);
        chk($sformatf("%s/b%0d/vld", tag, b), int'(out_vld_o), 1);
        chk($sformatf("%s/b%0d/start", tag, b), int'(out_start_o), s);
        chk($sformatf("%s/b%0d/len", tag, b), int'(out_len_o), l);
        chk($sformatf("%s/b%0d/ord", tag, b), int'(out_ord_o), b);
        chk($sformatf("%s/b%0d/last", tag, b), int'(out_last_o), (b == n - 1) ? 1 : 0);
        chk($sformatf("%s/b%0d/in_rdy", tag, b), int'(in_rdy_o), 0);
    endtask

    // Accept one vector, then walk its beats; with stall set, each beat is held one cycle first.
    task automatic run_vec(input logic [7:0] x, input int n, input logic [3:0][2:0] st,
                           input logic [3:0][3:0] ln, input bit stall, input string tag);
        @(negedge clk);
        chk({tag, "/in_rdy_idle"}, int'(in_rdy_o), 1);
        in_vld_i  = 1'b1;
        in_x_i    = x;
        out_rdy_i = 1'b0;
        @(negedge clk);
        in_vld_i = 1'b0;
        in_x_i   = 8'($urandom);
        for (int b = 0; b < n; b++) begin
            if (stall) begin
                out_rdy_i = 1'b0;
                check_beat({tag, "/hold"}, b, n, int'(st[b]), int'(ln[b]));
                @(negedge clk);
            end
            out_rdy_i = 1'b1;
            check_beat(tag, b, n, int'(st[b]), int'(ln[b]));
            @(negedge clk);
        end
        out_rdy_i = 1'b0;
        chk({tag, "/done_vld"}, int'(out_vld_o), 0);
        chk({tag, "/done_in_rdy"}, int'(in_rdy_o), 1);
    endtask

    // Reference: list runs of 1s scanning from bit 7 downward.
    task automatic model(input logic [7:0] x, output int n,
                         output logic [3:0][2:0] st, output logic [3:0][3:0] ln);
        bit in_run;
        n = 0;
        st = '0;
        ln = '0;
        in_run = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (x[i]) begin
                if (!in_run) begin
                    st[n] = 3'(i);
                    ln[n] = 4'd1;
                    n++;
                end else begin
                    ln[n-1] = ln[n-1] + 4'd1;
                end
                in_run = 1'b1;
            end else begin
                in_run = 1'b0;
            end
        end
        if (n == 0) n = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "/vld"}, int'(out_vld_o), 0);
        chk({tag, "/in_rdy"}, int'(in_rdy_o), 1);
        chk({tag, "/start"}, int'(out_start_o), 0);
        chk({tag, "/len"}, int'(out_len_o), 0);
        chk({tag, "/last"}, int'(out_last_o), 1);
        chk({tag, "/ord"}, int'(out_ord_o), 0);
    endtask

    vec_t tbl[8];

    initial begin
        int                n;
        logic [3:0][2:0]   st;
        logic [3:0][3:0]   ln;
        logic [7:0]        x;

        tbl[0] = '{x: 8'hE6, n: 3'd2, st: {3'd0, 3'd0, 3'd2, 3'd7}, ln: {4'd0, 4'd0, 4'd2, 4'd3}};
        tbl[1] = '{x: 8'hFF, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd7}, ln: {4'd0, 4'd0, 4'd0, 4'd8}};
        tbl[2] = '{x: 8'h03, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd1}, ln: {4'd0, 4'd0, 4'd0, 4'd2}};
        tbl[3] = '{x: 8'h00, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd0}, ln: {4'd0, 4'd0, 4'd0, 4'd0}};
        tbl[4] = '{x: 8'hAA, n: 3'd4, st: {3'd1, 3'd3, 3'd5, 3'd7}, ln: {4'd1, 4'd1, 4'd1, 4'd1}};
        tbl[5] = '{x: 8'h80, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd7}, ln: {4'd0, 4'd0, 4'd0, 4'd1}};
        tbl[6] = '{x: 8'h01, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd0}, ln: {4'd0, 4'd0, 4'd0, 4'd1}};
        tbl[7] = '{x: 8'h7E, n: 3'd1, st: {3'd0, 3'd0, 3'd0, 3'd6}, ln: {4'd0, 4'd0, 4'd0, 4'd6}};

        arst_n    = 1'b0;
        in_vld_i  = 1'b0;
        in_x_i    = '0;
        flush_i   = 1'b0;
        out_rdy_i = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        arst_n = 1'b1;

        for (int t = 0; t < 8; t++) begin
            run_vec(tbl[t].x, int'(tbl[t].n), tbl[t].st, tbl[t].ln, 1'b0,
                    $sformatf("tbl%0d", t));
        end
        // stalled consumer: every beat must hold while out_rdy_i is low
        run_vec(tbl[4].x, int'(tbl[4].n), tbl[4].st, tbl[4].ln, 1'b1, "stall_aa");

        // flush during the second beat while stalled
        @(negedge clk);
        in_vld_i = 1'b1;
        in_x_i   = 8'hAA;
        @(negedge clk);
        in_vld_i  = 1'b0;
        out_rdy_i = 1'b1;
        chk("flush/b0_start", int'(out_start_o), 7);
        @(negedge clk);
        out_rdy_i = 1'b0;
        chk("flush/b1_start", int'(out_start_o), 5);
        chk("flush/b1_ord", int'(out_ord_o), 1);
        flush_i = 1'b1;
        #1;
        chk("flush/in_rdy_blocked", int'(in_rdy_o), 0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush/vld_after", int'(out_vld_o), 0);
        chk("flush/in_rdy_after", int'(in_rdy_o), 1);
        run_vec(tbl[5].x, 1, tbl[5].st, tbl[5].ln, 1'b0, "after_flush");

        // flush in IDLE blocks acceptance and is otherwise a no-op
        @(negedge clk);
        flush_i  = 1'b1;
        in_vld_i = 1'b1;
        in_x_i   = 8'hFF;
        #1;
        chk("idle_flush/in_rdy", int'(in_rdy_o), 0);
        @(negedge clk);
        flush_i  = 1'b0;
        in_vld_i = 1'b0;
        #1;
        chk("idle_flush/vld", int'(out_vld_o), 0);
        chk("idle_flush/in_rdy", int'(in_rdy_o), 1);

        // asynchronous reset mid-vector
        @(negedge clk);
        in_vld_i = 1'b1;
        in_x_i   = 8'hE6;
        @(negedge clk);
        in_vld_i = 1'b0;
        chk("rst_mid/vld_before", int'(out_vld_o), 1);
        #2;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        arst_n = 1'b1;
        out_rdy_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_mid/no_stale%0d", c), int'(out_vld_o), 0);
        end
        out_rdy_i = 1'b0;
        run_vec(tbl[2].x, 1, tbl[2].st, tbl[2].ln, 1'b0, "after_rst");

        // random vectors against the run-list model
        for (int r = 0; r < 40; r++) begin
            x = 8'($urandom);
            model(x, n, st, ln);
            run_vec(x, n, st, ln, bit'($urandom_range(0, 1)), $sformatf("rnd%0d_%02h", r, x));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
